// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the requesters and memory.
interface mem_port_arbiter_if #(
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 15
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [BUS_WIDTH-1:0]  i_rdata;
    logic                  i_stall;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [BUS_WIDTH-1:0]  d_wdata;
    logic                  d_ack;
    logic [BUS_WIDTH-1:0]  d_rdata;
    logic                  d_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic                  mem_ack;
    logic [BUS_WIDTH-1:0]  mem_rdata;

    logic                  err_spurious;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, err_spurious
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, err_spurious
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter: data side has priority, a starvation counter
// forces an instruction grant after MAX_DGRANT data grants while fetch waits.
module mem_port_arbiter #(
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 15,
    parameter int MAX_DGRANT = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BUS_WIDTH-1:0]  r_mem_wdata;
    logic [BUS_WIDTH-1:0]  r_i_rdata;
    logic [BUS_WIDTH-1:0]  r_d_rdata;
    logic                  r_err;

    logic                  w_starved;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_in_wait;

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_starved = bus.i_req && (r_starve_cnt == CNT_W'(MAX_DGRANT));
        case (r_state)
            IDLE: begin
                if (bus.d_req && !w_starved) begin
                    w_grant_d = 1'b1;
                    w_next    = WAIT_D;
                end else if (bus.i_req) begin
                    w_grant_i = 1'b1;
                    w_next    = WAIT_I;
                end
            end
            WAIT_I:  if (bus.mem_ack) w_next = RESP_I;
            WAIT_D:  if (bus.mem_ack) w_next = RESP_D;
            // Requests are deliberately not sampled here so a held req is not re-issued.
            RESP_I:  w_next = IDLE;
            RESP_D:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    assign w_in_wait = (r_state == WAIT_I) || (r_state == WAIT_D);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_mem_req <= w_grant_d || w_grant_i;

            if (w_grant_d) begin
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.i_addr;
            end

            if (w_grant_i)
                r_starve_cnt <= '0;
            else if (w_grant_d && bus.i_req && r_starve_cnt != CNT_W'(MAX_DGRANT))
                r_starve_cnt <= r_starve_cnt + 1'b1;

            if (r_state == WAIT_I && bus.mem_ack)
                r_i_rdata <= bus.mem_rdata;
            if (r_state == WAIT_D && bus.mem_ack && !r_mem_we)
                r_d_rdata <= bus.mem_rdata;

            // Acks outside a wait belong to nothing we issued (e.g. abandoned by reset).
            if (bus.mem_ack && !w_in_wait)
                r_err <= 1'b1;
        end
    end

    assign bus.i_ack        = (r_state == RESP_I);
    assign bus.d_ack        = (r_state == RESP_D);
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.i_stall      = bus.i_req && !bus.i_ack;
    assign bus.d_stall      = bus.d_req && !bus.d_ack;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.err_spurious = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model
// that can also inject stray acks.
module tb_mem_port_arbiter;
    localparam int BW = 64;
    localparam int AW = 15;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DGRANT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [BW-1:0] mem [0:(1<<AW)-1];
    bit            auto_ack = 1'b1;
    int            inj_req  = 0;
    int            inj_seen = 0;
    logic [BW-1:0] inj_data = '0;
    int            lat_cnt  = 0;
    string         exp_order = "DDDIDDDI";
    int            g, acks, issues, dup;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.mem_req;
            1:       return bus.i_ack;
            default: return bus.d_ack;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        for (int k = 0; k < 50; k++) begin
            if (sig(sel)) break;
            tick();
        end
        check(tag, 64'(sig(sel)), 64'd1);
    endtask

    // Memory model: runs on the falling edge so its outputs are settled for the DUT.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                end
            end
            if (inj_req != inj_seen) begin
                inj_seen      = inj_req;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = inj_data;
            end
            if (bus.mem_req && auto_ack) begin
                lat_cnt = L;
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end
        end
    end

    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        mem[15'h010] = 64'h0000_0000_DEAD_BEEF;
        mem[15'h100] = 64'h1111_2222_3333_4444;
        mem[15'h200] = 64'hAAAA_0000_BBBB_0001;

        // Reset state
        rst = 0; tick(); tick();
        check("rst_mem_req", 64'(bus.mem_req), 0);
        check("rst_mem_we", 64'(bus.mem_we), 0);
        check("rst_mem_addr", 64'(bus.mem_addr), 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_acks", 64'({bus.i_ack, bus.d_ack}), 0);
        check("rst_err", 64'(bus.err_spurious), 0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        check("rst_state", 64'(dut.r_state), 0);
        check("rst_starve", 64'(dut.r_starve_cnt), 0);
        rst = 1; tick();

        // Data read, L=2
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 15'h010; #1;
        check("t1_stall_c0", 64'(bus.d_stall), 1);
        tick();
        check("t1_mem_req_c1", 64'(bus.mem_req), 1);
        check("t1_mem_addr", 64'(bus.mem_addr), 64'h010);
        check("t1_mem_we", 64'(bus.mem_we), 0);
        check("t1_stall_c1", 64'(bus.d_stall), 1);
        tick();
        check("t1_mem_req_c2", 64'(bus.mem_req), 0);
        check("t1_stall_c2", 64'(bus.d_stall), 1);
        tick();
        check("t1_ack_c3", 64'(bus.d_ack), 0);
        check("t1_stall_c3", 64'(bus.d_stall), 1);
        tick();
        check("t1_ack_c4", 64'(bus.d_ack), 1);
        check("t1_rdata", bus.d_rdata, 64'hDEAD_BEEF);
        check("t1_stall_c4", 64'(bus.d_stall), 0);
        bus.d_req = 0;
        tick();
        check("t1_ack_c5", 64'(bus.d_ack), 0);
        check("t1_rdata_hold", bus.d_rdata, 64'hDEAD_BEEF);

        // Simultaneous requests: data write first, then fetch
        bus.i_addr = 15'h100; bus.i_req = 1;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 15'h020; bus.d_wdata = 64'h55;
        tick();
        check("t2_mem_req", 64'(bus.mem_req), 1);
        check("t2_mem_we", 64'(bus.mem_we), 1);
        check("t2_mem_addr", 64'(bus.mem_addr), 64'h020);
        check("t2_mem_wdata", bus.mem_wdata, 64'h55);
        check("t2_i_stall", 64'(bus.i_stall), 1);
        wait_for(2, "t2_d_ack_timeout");
        check("t2_i_ack_early", 64'(bus.i_ack), 0);
        check("t2_d_rdata_kept", bus.d_rdata, 64'hDEAD_BEEF);
        bus.d_req = 0; bus.d_we = 0;
        check("t2_mem_written", mem[15'h020], 64'h55);
        tick();
        check("t2_idle_no_req", 64'(bus.mem_req), 0);
        tick();
        check("t2_i_issue", 64'(bus.mem_req), 1);
        check("t2_i_we", 64'(bus.mem_we), 0);
        check("t2_i_addr", 64'(bus.mem_addr), 64'h100);
        wait_for(1, "t2_i_ack_timeout");
        check("t2_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
        bus.i_req = 0;
        tick();

        // Continuous requests: starvation order, no duplicate issues
        bus.i_req = 1; bus.i_addr = 15'h100;
        bus.d_req = 1; bus.d_addr = 15'h200; bus.d_we = 0;
        g = 0; acks = 0; issues = 0; dup = 0;
        for (int c = 0; c < 200 && (g < 8 || acks < issues); c++) begin
            tick();
            if (bus.i_ack || bus.d_ack) acks++;
            if (bus.mem_req) begin
                if (bus.i_ack || bus.d_ack) dup++;
                issues++;
                if (g < 8) begin
                    check($sformatf("t3_grant%0d", g),
                          (bus.mem_addr == 15'h100) ? 64'h49 : 64'h44, 64'(exp_order[g]));
                    if (g == 2) check("t3_starve_sat", 64'(dut.r_starve_cnt), 3);
                    if (bus.mem_addr == 15'h100)
                        check($sformatf("t3_starve_clr%0d", g), 64'(dut.r_starve_cnt), 0);
                end
                g++;
            end
        end
        bus.i_req = 0; bus.d_req = 0;
        check("t3_grants", 64'(g), 8);
        check("t3_issue_eq_ack", 64'(issues), 64'(acks));
        check("t3_dup_issue", 64'(dup), 0);
        tick(); tick();
        check("t3_quiet", 64'(bus.mem_req), 0);

        // Stray ack in IDLE
        inj_data = 64'hBAD; inj_req++;
        tick();
        check("t6_err", 64'(bus.err_spurious), 1);
        check("t6_acks", 64'({bus.i_ack, bus.d_ack}), 0);
        check("t6_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
        check("t6_d_rdata", bus.d_rdata, 64'hAAAA_0000_BBBB_0001);
        check("t6_state", 64'(dut.r_state), 0);
        tick(); tick();
        check("t6_err_sticky", 64'(bus.err_spurious), 1);

        // Reset during WAIT_D, late ack afterwards
        rst = 0; tick();
        check("t5_err_clr", 64'(bus.err_spurious), 0);
        check("t5_rdata_clr", bus.d_rdata, 0);
        rst = 1; tick();
        auto_ack = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 15'h030;
        tick();
        check("t5_wait_d", 64'(dut.r_state), 2);
        check("t5_issue", 64'(bus.mem_req), 1);
        rst = 0; bus.d_req = 0;
        tick();
        check("t5_rst_idle", 64'(dut.r_state), 0);
        check("t5_rst_req", 64'(bus.mem_req), 0);
        rst = 1;
        tick();
        check("t5_no_ack_a", 64'(bus.d_ack), 0);
        tick();
        inj_data = 64'h77; inj_req++;
        tick();
        check("t5_err", 64'(bus.err_spurious), 1);
        check("t5_no_ack_b", 64'(bus.d_ack), 0);
        check("t5_state", 64'(dut.r_state), 0);
        check("t5_d_rdata", bus.d_rdata, 0);
        tick();
        check("t5_no_ack_c", 64'(bus.d_ack), 0);
        auto_ack = 1;
        bus.i_req = 1; bus.i_addr = 15'h100;
        wait_for(1, "t5_i_ack_timeout");
        check("t5_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
        bus.i_req = 0;
        tick();
        check("t5_err_sticky", 64'(bus.err_spurious), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (read-only) and the data-access requester in the MEM stage (read/write).
- Sequences one transaction at a time. The data side has priority; an anti-starvation counter guarantees instruction fetch progress.
- Generates per-requester stall signals. These are ORed into the pipeline stall network next to the compulsory and load stalls.

Parameters:
- BUS_WIDTH, 64, data width of rdata/wdata on all ports.
- ADDR_WIDTH, 15, word address width.
- MAX_DGRANT, 3, consecutive data grants allowed while an instruction request waits; range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  ADDR_WIDTH  instruction address; stable while i_req.
- i_ack  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  BUS_WIDTH  fetched word.
- i_stall  out  1  i_req & ~i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  BUS_WIDTH  write data.
- d_ack  out  1  one-cycle pulse: done; d_rdata valid for reads.
- d_rdata  out  BUS_WIDTH  read data.
- d_stall  out  1  d_req & ~d_ack.
- mem_req  out  1  one-cycle issue pulse to memory.
- mem_we  out  1  latched write enable.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_wdata  out  BUS_WIDTH  latched write data.
- mem_ack  in  1  memory completion pulse, arbitrary latency ≥1 cycle after mem_req.
- mem_rdata  in  BUS_WIDTH  valid with mem_ack.
- err_spurious  out  1  sticky: mem_ack seen outside WAIT_I/WAIT_D.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, starve_cnt=0.
  - mem_req, mem_we, i_ack, d_ack and err_spurious = 0.
  - mem_addr, mem_wdata, i_rdata and d_rdata = 0.
- Reset mid-transaction: the transaction is abandoned and no ack is produced. A later mem_ack from that transaction sets err_spurious.
- States: IDLE, WAIT_I, WAIT_D, RESP_I, RESP_D.
- IDLE, grant decision (registered):
  - d_req & ~(i_req & starve_cnt==MAX_DGRANT) → grant data. Latch d_we/d_addr/d_wdata, mem_req=1 next cycle, go to WAIT_D.
  - Else if i_req → grant instruction. Latch i_addr, mem_we=0, mem_req=1 next cycle, go to WAIT_I.
  - Else stay in IDLE.
- starve_cnt:
  - +1 (saturating at MAX_DGRANT) on a data grant while i_req=1.
  - Cleared on every instruction grant.
  - Unchanged on a data grant while i_req=0.
- WAIT_x:
  - mem_req is high only in the first WAIT cycle.
  - mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - On mem_ack: register mem_rdata into x_rdata and go to RESP_x.
- RESP_x:
  - x_ack=1 for exactly this cycle, then go to IDLE.
  - Requests are not sampled in RESP, so a still-high req is not re-issued.
  - A requester may present a new request in the cycle after ack.
- x_rdata holds its value until the next completion on that port. For writes, d_rdata is unchanged.
- Latency: req high in IDLE at cycle 0 → mem_req at cycle 1 → mem_ack at cycle 1+L → x_ack at cycle 2+L. The next issue is at cycle 4+L at the earliest.
- mem_ack in IDLE or RESP: ignored for data, sets err_spurious. It is cleared only by reset.
- Requests dropped before ack are a protocol violation. The latched transaction still completes and acks.
- i_stall and d_stall are combinational, so a waiting requester stalls from the cycle its req rises.

Test Plan:
- Memory model L=2, data read d_addr=0x010 returning 0xDEAD_BEEF: req at cycle 0 → mem_req at cycle 1, mem_ack at cycle 3, d_ack and d_rdata=0xDEADBEEF at cycle 4, d_stall high cycles 0–3.
- i_req and d_req rise together, d_we=1, d_addr=0x020, d_wdata=0x55 → data issued first with mem_we=1 and mem_wdata=0x55. The instruction is issued at the first IDLE after d_ack with mem_we=0.
- i_req and d_req held continuously, MAX_DGRANT=3 → grant order D,D,D,I,D,D,D,I; starve_cnt returns to 0 after each I grant.
- req held high through RESP with the same address → exactly one mem_req per ack, never a duplicate issue in the RESP cycle.
- rst=0 asserted in WAIT_D, then mem_ack arrives 2 cycles after release → no d_ack, err_spurious=1, state IDLE. A following i_req completes normally.
- mem_ack injected in IDLE → err_spurious=1 and stays 1, i_ack=d_ack=0, no rdata change.
